level_loader_pipelined: RTL

//  Parametrised grid loader. On start it streams every cell of a GRID_W x GRID_H
//  map into the game grid RAM, one write per cycle, through a write port
//  (grid_x/grid_y/grid_in/grid_write).

---
 rtl/level_loader_pipelined_if.sv | 38 +++
 rtl/level_loader_pipelined.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/level_loader_pipelined_if.sv
// Bus between the game-control FSM / level ROM side and the grid loader.
interface level_loader_pipelined_if #(
    parameter int X_BITS     = 6,
    parameter int Y_BITS     = 5,
    parameter int CELL_BITS  = 3,
    parameter int LEVEL_BITS = 2
);
    logic                        start;
    logic                        mode;
    logic [LEVEL_BITS-1:0]       level;
    logic [CELL_BITS-1:0]        fill_value;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic [LEVEL_BITS-1:0]       rom_level;
    logic [X_BITS-1:0]           rom_x;
    logic [Y_BITS-1:0]           rom_y;
    logic [CELL_BITS-1:0]        rom_data;
    logic [X_BITS-1:0]           grid_x;
    logic [Y_BITS-1:0]           grid_y;
    logic [CELL_BITS-1:0]        grid_in;
    logic                        grid_write;
    logic [X_BITS+Y_BITS:0]      wall_count;

    // Controller/ROM side
    modport master (
        output start, mode, level, fill_value, abort, rom_data,
        input  busy, done, rom_level, rom_x, rom_y,
               grid_x, grid_y, grid_in, grid_write, wall_count
    );

    // Loader side
    modport slave (
        input  start, mode, level, fill_value, abort, rom_data,
        output busy, done, rom_level, rom_x, rom_y,
               grid_x, grid_y, grid_in, grid_write, wall_count
    );
endinterface

// File: rtl/level_loader_pipelined.sv
// Grid loader: streams GRID_W x GRID_H cells into the grid RAM, one write per
// cycle, from a fixed-latency level ROM (LOAD) or a constant (FILL), and counts
// the non-zero (wall) cells written.
module level_loader_pipelined #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int X_BITS      = 6,
    parameter int Y_BITS      = 5,
    parameter int CELL_BITS   = 3,
    parameter int LEVEL_BITS  = 2,
    parameter int ROM_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    level_loader_pipelined_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                WC_BITS = X_BITS + Y_BITS + 1;
    localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST  = Y_BITS'(GRID_H - 1);

    logic [1:0]                              r_state;
    logic                                    r_mode;
    logic [LEVEL_BITS-1:0]                   r_level;
    logic [CELL_BITS-1:0]                    r_fill;
    logic [X_BITS-1:0]                       r_x;
    logic [Y_BITS-1:0]                       r_y;
    logic [ROM_LATENCY-1:0]                  r_vld_pipe;
    logic [ROM_LATENCY-1:0][X_BITS-1:0]      r_x_pipe;
    logic [ROM_LATENCY-1:0][Y_BITS-1:0]      r_y_pipe;
    logic [X_BITS-1:0]                       r_grid_x;
    logic [Y_BITS-1:0]                       r_grid_y;
    logic [CELL_BITS-1:0]                    r_grid_in;
    logic                                    r_grid_write;
    logic [WC_BITS-1:0]                      r_wall;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last_cell;
    logic                  w_abort;
    logic                  w_exit_vld;
    logic                  w_pipe_empty;
    logic [CELL_BITS-1:0]  w_cell;

    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_issue      = (r_state == S_ISSUE);
    assign w_last_cell  = (r_x == X_LAST) && (r_y == Y_LAST);
    // abort only matters while cells are still in flight
    assign w_abort      = bus.abort && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_exit_vld   = r_vld_pipe[ROM_LATENCY-1];
    assign w_pipe_empty = ~|r_vld_pipe;
    // rom_data lines up with the entry leaving the pipe this cycle
    assign w_cell       = r_mode ? r_fill : bus.rom_data;

    // Control FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE, abort returns to IDLE
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) r_state <= S_ISSUE;
                S_ISSUE: begin
                    if (bus.abort)       r_state <= S_IDLE;
                    else if (w_last_cell) r_state <= S_DRAIN;
                end
                // empty pipe in DRAIN means the final write is on the bus now
                S_DRAIN: begin
                    if (bus.abort)        r_state <= S_IDLE;
                    else if (w_pipe_empty) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Latch load settings at start and walk the row-major address counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_mode  <= 1'b0;
            r_level <= '0;
            r_fill  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_accept) begin
            r_mode  <= bus.mode;
            r_level <= bus.level;
            r_fill  <= bus.fill_value;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_issue && !w_last_cell) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Carry {valid,x,y} alongside the ROM access; same depth in FILL mode
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_vld_pipe <= '0;
            r_x_pipe   <= '0;
            r_y_pipe   <= '0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            r_x_pipe[0]   <= r_x;
            r_y_pipe[0]   <= r_y;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_x_pipe[i]   <= r_x_pipe[i-1];
                r_y_pipe[i]   <= r_y_pipe[i-1];
            end
            if (w_abort) r_vld_pipe <= '0;
        end
    end

    // Register the grid write port and count non-zero cells written
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_grid_x     <= '0;
            r_grid_y     <= '0;
            r_grid_in    <= '0;
            r_grid_write <= 1'b0;
            r_wall       <= '0;
        end else begin
            r_grid_write <= 1'b0;
            if (w_accept) begin
                r_wall <= '0;
            end else if (w_exit_vld && !w_abort) begin
                r_grid_x     <= r_x_pipe[ROM_LATENCY-1];
                r_grid_y     <= r_y_pipe[ROM_LATENCY-1];
                r_grid_in    <= w_cell;
                r_grid_write <= 1'b1;
                if (w_cell != '0) r_wall <= r_wall + 1'b1;
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.rom_level  = r_level;
    assign bus.rom_x      = r_x;
    assign bus.rom_y      = r_y;
    assign bus.grid_x     = r_grid_x;
    assign bus.grid_y     = r_grid_y;
    assign bus.grid_in    = r_grid_in;
    assign bus.grid_write = r_grid_write;
    assign bus.wall_count = r_wall;
endmodule
